// File: rtl/order_4s.sv
// -----------------------------------------------------------------------------
// order_4s -- measurement frame sequencer for the ultrasound front end.
//
// After a start command the block repeats a fixed-length frame (4 s at 50 MHz
// with the default parameters). It can also run exactly one frame. Each frame
// produces three pulses:
//   * start_test : marks frame cycle 0 (for the scope and for debug)
//   * Exc_start  : excitation trigger for the transmit driver
//   * AD_start   : delayed acquisition trigger for the ADC capture block
//
// A stop command, the end of a single frame or reset returns the block to idle.
//
// Ports
//   clk_50M    in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   command    in   3  1 = run continuous, 2 = stop, 3 = single frame,
//                      any other code does nothing
//   start      out  1  high while a sequence is active
//   start_test out  1  one-cycle pulse at frame cycle 0
//   Exc_start  out  1  high for frame cycles 0 .. EXC_WIDTH-1
//   AD_start   out  1  high for frame cycles AD_DELAY .. AD_DELAY+AD_WIDTH-1
// -----------------------------------------------------------------------------
module order_4s #(
  parameter int unsigned PERIOD_CYCLES = 200_000_000,
  parameter int unsigned EXC_WIDTH     = 5,
  parameter int unsigned AD_DELAY      = 500,
  parameter int unsigned AD_WIDTH      = 5
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic [2:0] command,
  output logic       start,
  output logic       start_test,
  output logic       Exc_start,
  output logic       AD_start
);

  localparam int unsigned FW = $clog2(PERIOD_CYCLES);

  // The window bounds are compared one bit wider than the counter, because
  // AD_DELAY+AD_WIDTH and EXC_WIDTH may equal PERIOD_CYCLES, and that value
  // does not always fit in FW bits.
  localparam logic [FW-1:0] FCNT_LAST = FW'(PERIOD_CYCLES - 1);
  localparam logic [FW:0]   EXC_END   = (FW + 1)'(EXC_WIDTH);
  localparam logic [FW:0]   AD_BEGIN  = (FW + 1)'(AD_DELAY);
  localparam logic [FW:0]   AD_END    = (FW + 1)'(AD_DELAY + AD_WIDTH);

  localparam logic [2:0] CMD_RUN    = 3'h1;
  localparam logic [2:0] CMD_STOP   = 3'h2;
  localparam logic [2:0] CMD_SINGLE = 3'h3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_SINGLE
  } state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [FW-1:0] fcnt_inc;
  logic          fcnt_last;
  logic          active_d;
  logic          start_q, start_d;
  logic          start_test_q, start_test_d;
  logic          exc_q, exc_d;
  logic          ad_q, ad_d;

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    fcnt_last = (fcnt_q == FCNT_LAST);
    // The wrap goes straight from the last cycle to 0, so frames follow each
    // other with no dead cycle in between.
    fcnt_inc  = fcnt_last ? '0 : fcnt_q + FW'(1);

    case (state_q)
      ST_IDLE: begin
        fcnt_d = '0;
        if (command == CMD_RUN) begin
          state_d = ST_RUN;
        end else if (command == CMD_SINGLE) begin
          state_d = ST_SINGLE;
        end
      end
      ST_RUN: begin
        // Run and single commands are ignored here, so the frame never restarts.
        if (command == CMD_STOP) begin
          state_d = ST_IDLE;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_inc;
        end
      end
      ST_SINGLE: begin
        if (command == CMD_STOP || fcnt_last) begin
          state_d = ST_IDLE;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        fcnt_d  = '0;
      end
    endcase

    // The outputs are decoded from the next state and the next count, so they
    // register on the same edge as the state. A start shows frame cycle 0 on
    // the edge that samples the command. A stop clears every output on the
    // edge that samples it.
    active_d     = (state_d != ST_IDLE);
    start_d      = active_d;
    start_test_d = active_d && (fcnt_d == '0);
    exc_d        = active_d && ({1'b0, fcnt_d} < EXC_END);
    ad_d         = active_d && ({1'b0, fcnt_d} >= AD_BEGIN) && ({1'b0, fcnt_d} < AD_END);
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fcnt_q       <= '0;
      start_q      <= 1'b0;
      start_test_q <= 1'b0;
      exc_q        <= 1'b0;
      ad_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      start_q      <= start_d;
      start_test_q <= start_test_d;
      exc_q        <= exc_d;
      ad_q         <= ad_d;
    end
  end

  assign start      = start_q;
  assign start_test = start_test_q;
  assign Exc_start  = exc_q;
  assign AD_start   = ad_q;

endmodule

// File: tb/tb_order_4s.sv
// -----------------------------------------------------------------------------
// tb_order_4s -- directed bench for order_4s.
//
// Two instances share the clock and the reset:
//   * dut uses short frames (PERIOD=1000, EXC=2, AD_DELAY=20, AD_WIDTH=3)
//     to test continuous, stop, single and reset behaviour.
//   * dut_def uses the default parameters to test the first-frame pulse
//     placement.
// The outputs are sampled 1 ns after each rising edge. The inputs are driven
// at the same point, so the next edge samples them.
// -----------------------------------------------------------------------------
module tb_order_4s;

  localparam int P  = 1000;
  localparam int EW = 2;
  localparam int AD = 20;
  localparam int AW = 3;

  logic       clk_50M = 1'b0;
  logic       rst_n;
  logic [2:0] cmd;
  logic [2:0] cmd_def;

  logic start, start_test, exc_start, ad_start;
  logic d_start, d_start_test, d_exc_start, d_ad_start;
  logic [3:0] outs;
  logic [3:0] outs_def;

  int checks = 0;
  int errors = 0;

  always #10 clk_50M = ~clk_50M;

  order_4s #(
    .PERIOD_CYCLES(P),
    .EXC_WIDTH    (EW),
    .AD_DELAY     (AD),
    .AD_WIDTH     (AW)
  ) dut (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .command   (cmd),
    .start     (start),
    .start_test(start_test),
    .Exc_start (exc_start),
    .AD_start  (ad_start)
  );

  order_4s dut_def (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .command   (cmd_def),
    .start     (d_start),
    .start_test(d_start_test),
    .Exc_start (d_exc_start),
    .AD_start  (d_ad_start)
  );

  // Bit order: {start, start_test, Exc_start, AD_start}
  assign outs     = {start, start_test, exc_start, ad_start};
  assign outs_def = {d_start, d_start_test, d_exc_start, d_ad_start};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  // Expected outputs for the short-frame instance at frame cycle c:
  // Exc_start is high in cycles 0..1 and AD_start in cycles 20..22.
  function automatic logic [3:0] frame_exp(input int c);
    return {1'b1, (c == 0), (c < 2), (c >= 20) && (c < 23)};
  endfunction

  // Expected outputs for the default instance: Exc_start is high in
  // cycles 0..4 and AD_start in cycles 500..504.
  function automatic logic [3:0] frame_exp_def(input int c);
    return {1'b1, (c == 0), (c < 5), (c >= 500) && (c < 505)};
  endfunction

  int noop_codes [6] = '{0, 2, 4, 5, 6, 7};

  initial begin
    // Hold reset with a run command present. Nothing may start.
    rst_n   = 1'b0;
    cmd     = 3'h1;
    cmd_def = 3'h1;
    repeat (4) begin
      tick();
      check_eq("rst_hold", 32'(outs), 32'h0);
      check_eq("rst_hold_def", 32'(outs_def), 32'h0);
    end
    cmd     = 3'h0;
    cmd_def = 3'h0;
    rst_n   = 1'b1;
    tick();
    check_eq("idle_after_rst", 32'(outs), 32'h0);
    check_eq("idle_after_rst_def", 32'(outs_def), 32'h0);
    $display("phase reset done");

    // Default parameters: hold the run command for three edges, then check
    // the first 600 cycles of the frame.
    cmd_def = 3'h1;
    for (int i = 0; i < 600; i++) begin
      tick();
      check_eq($sformatf("def_frame c%0d", i), 32'(outs_def), 32'(frame_exp_def(i)));
      if (i == 2) cmd_def = 3'h0;
    end
    $display("phase default_start done");

    // No-op codes, and stop, while idle.
    foreach (noop_codes[k]) begin
      cmd = 3'(noop_codes[k]);
      tick();
      check_eq($sformatf("noop code%0d", noop_codes[k]), 32'(outs), 32'h0);
    end
    cmd = 3'h0;
    $display("phase noop done");

    // Continuous run. Hold run for 10 edges, which must give a single start.
    // Check three full frames plus cycles 0..20 of the fourth frame. Then stop
    // at frame cycle 21 while AD_start is high.
    cmd = 3'h1;
    for (int i = 0; i <= 3 * P + 20; i++) begin
      tick();
      check_eq($sformatf("run c%0d", i), 32'(outs), 32'(frame_exp(i % P)));
      if (i == 9) cmd = 3'h0;
      if (i == 3 * P + 20) cmd = 3'h2;
    end
    tick();
    check_eq("stop_mid_ad", 32'(outs), 32'h0);
    cmd = 3'h0;
    for (int i = 0; i < 1200; i++) begin
      tick();
      check_eq($sformatf("after_stop c%0d", i), 32'(outs), 32'h0);
    end
    $display("phase continuous_stop done");

    // Run, stop, then run again right away. A held run does not restart.
    cmd = 3'h1;
    tick();
    check_eq("restart_a0", 32'(outs), 32'(frame_exp(0)));
    cmd = 3'h2;
    tick();
    check_eq("restart_stop", 32'(outs), 32'h0);
    cmd = 3'h1;
    tick();
    check_eq("restart_b0", 32'(outs), 32'(frame_exp(0)));
    tick();
    check_eq("restart_b1", 32'(outs), 32'(frame_exp(1)));
    cmd = 3'h2;
    tick();
    check_eq("restart_stop2", 32'(outs), 32'h0);
    cmd = 3'h0;
    tick();
    check_eq("restart_idle", 32'(outs), 32'h0);
    $display("phase restart done");

    // Single frame. A run command in mid-frame is ignored. The sequence then
    // ends after exactly P cycles.
    cmd = 3'h3;
    for (int i = 0; i < P + 5; i++) begin
      tick();
      check_eq($sformatf("single c%0d", i), 32'(outs), (i < P) ? 32'(frame_exp(i)) : 32'h0);
      if (i == 0)   cmd = 3'h0;
      if (i == 500) cmd = 3'h1;
      if (i == 505) cmd = 3'h0;
    end
    $display("phase single done");

    // Single frame with a stop sampled on the terminal edge.
    cmd = 3'h3;
    for (int i = 0; i <= P; i++) begin
      tick();
      check_eq($sformatf("single_stop c%0d", i), 32'(outs), (i < P) ? 32'(frame_exp(i)) : 32'h0);
      if (i == 0)     cmd = 3'h0;
      if (i == P - 1) cmd = 3'h2;
    end
    cmd = 3'h0;
    tick();
    check_eq("single_stop_idle", 32'(outs), 32'h0);
    $display("phase single_terminal_stop done");

    // Assert reset between clock edges in mid-frame. The outputs must clear
    // before the next edge.
    cmd = 3'h1;
    for (int i = 0; i < 30; i++) begin
      tick();
      check_eq($sformatf("pre_arst c%0d", i), 32'(outs), 32'(frame_exp(i)));
      if (i == 0) cmd = 3'h0;
    end
    #5;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_clear", 32'(outs), 32'h0);
    cmd = 3'h1;
    tick();
    check_eq("arst_hold0", 32'(outs), 32'h0);
    tick();
    check_eq("arst_hold1", 32'(outs), 32'h0);
    cmd   = 3'h0;
    rst_n = 1'b1;
    tick();
    check_eq("arst_release_idle", 32'(outs), 32'h0);
    cmd = 3'h1;
    tick();
    check_eq("arst_restart0", 32'(outs), 32'(frame_exp(0)));
    tick();
    check_eq("arst_restart1", 32'(outs), 32'(frame_exp(1)));
    cmd = 3'h2;
    tick();
    check_eq("arst_final_stop", 32'(outs), 32'h0);
    cmd = 3'h0;
    $display("phase async_reset done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
